// File: rtl/sram_sp_arbiter.sv
// Two-port arbiter in front of a single-port SRAM with optional grant locking
// (bounded to 16 grants) and in-order read-response routing via a tag pipe.
module sram_sp_arbiter #(
    parameter int DATA_BIT = 128,
    parameter int DEPTH    = 128,
    parameter int ADDR_BIT = $clog2(DEPTH),
    parameter int RD_LAT   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                a_req_valid,
    input  logic                a_req_wen,
    input  logic                a_req_lock,
    input  logic [ADDR_BIT-1:0] a_req_addr,
    input  logic [DATA_BIT-1:0] a_req_wdata,
    output logic                a_req_ready,
    output logic                a_rsp_valid,
    output logic [DATA_BIT-1:0] a_rsp_rdata,
    input  logic                b_req_valid,
    input  logic                b_req_wen,
    input  logic                b_req_lock,
    input  logic [ADDR_BIT-1:0] b_req_addr,
    input  logic [DATA_BIT-1:0] b_req_wdata,
    output logic                b_req_ready,
    output logic                b_rsp_valid,
    output logic [DATA_BIT-1:0] b_rsp_rdata,
    output logic [ADDR_BIT-1:0] sram_addr,
    output logic                sram_wen,
    output logic                sram_ren,
    output logic [DATA_BIT-1:0] sram_wdata,
    input  logic [DATA_BIT-1:0] sram_rdata
);

    // Handshake: a request transfers on a rising edge where x_req_valid and
    // x_req_ready are both 1; ready never depends on the requester's ready-wait.
    typedef enum logic [1:0] {RR_A, RR_B, LOCK_A, LOCK_B} state_t;

    // The locking grant plus 15 more in LOCK make 16 consecutive grants.
    localparam logic [3:0] BURST_LAST = 4'd14;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       burst_cnt;
    logic [3:0]       burst_cnt_nxt;
    logic             grant_a;
    logic             grant_b;
    logic [RD_LAT-1:0][1:0] tag_q;
    logic [1:0]       tag_out;

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        case (state)
            RR_A: begin
                grant_a = a_req_valid;
                grant_b = b_req_valid & ~a_req_valid;
            end
            RR_B: begin
                grant_b = b_req_valid;
                grant_a = a_req_valid & ~b_req_valid;
            end
            LOCK_A: grant_a = a_req_valid;
            LOCK_B: grant_b = b_req_valid;
            default: ;
        endcase
        if (!rst_n) begin
            grant_a = 1'b0;
            grant_b = 1'b0;
        end
    end

    assign a_req_ready = grant_a;
    assign b_req_ready = grant_b;

    always_comb begin
        state_nxt     = state;
        burst_cnt_nxt = burst_cnt;
        case (state)
            RR_A, RR_B: begin
                if (grant_a) begin
                    if (a_req_lock) begin
                        state_nxt     = LOCK_A;
                        burst_cnt_nxt = 4'd0;
                    end else begin
                        state_nxt = RR_B;
                    end
                end else if (grant_b) begin
                    if (b_req_lock) begin
                        state_nxt     = LOCK_B;
                        burst_cnt_nxt = 4'd0;
                    end else begin
                        state_nxt = RR_A;
                    end
                end
            end
            LOCK_A: begin
                if (grant_a && a_req_lock && burst_cnt != BURST_LAST) begin
                    burst_cnt_nxt = burst_cnt + 4'd1;
                end else begin
                    state_nxt = RR_B;
                end
            end
            LOCK_B: begin
                if (grant_b && b_req_lock && burst_cnt != BURST_LAST) begin
                    burst_cnt_nxt = burst_cnt + 4'd1;
                end else begin
                    state_nxt = RR_A;
                end
            end
            default: state_nxt = RR_A;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RR_A;
            burst_cnt <= 4'd0;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

    always_comb begin
        sram_addr  = '0;
        sram_wdata = '0;
        sram_wen   = 1'b0;
        sram_ren   = 1'b0;
        if (grant_a) begin
            sram_addr  = a_req_addr;
            sram_wdata = a_req_wdata;
            sram_wen   = a_req_wen;
            sram_ren   = ~a_req_wen;
        end else if (grant_b) begin
            sram_addr  = b_req_addr;
            sram_wdata = b_req_wdata;
            sram_wen   = b_req_wen;
            sram_ren   = ~b_req_wen;
        end
    end

    // Tag = {read issued, port (1 = B)}; writes and idle cycles push 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q <= '0;
        end else begin
            tag_q[0] <= {sram_ren, grant_b & sram_ren};
            for (int i = 1; i < RD_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign tag_out     = tag_q[RD_LAT-1];
    assign a_rsp_valid = tag_out[1] & ~tag_out[0];
    assign b_rsp_valid = tag_out[1] & tag_out[0];
    assign a_rsp_rdata = a_rsp_valid ? sram_rdata : '0;
    assign b_rsp_rdata = b_rsp_valid ? sram_rdata : '0;

endmodule

// File: tb/tb_sram_sp_arbiter.sv
// Randomised scoreboard bench for sram_sp_arbiter: an abstract arbiter/memory
// model predicts grants, SRAM strobes and read responses.
module tb_sram_sp_arbiter;

    localparam int DW  = 32;
    localparam int DEP = 16;
    localparam int AW  = 4;
    localparam int LAT = 2;
    localparam int EW  = 32 + 1 + DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_req_valid, a_req_wen, a_req_lock;
    logic [AW-1:0] a_req_addr;
    logic [DW-1:0] a_req_wdata;
    logic          a_req_ready, a_rsp_valid;
    logic [DW-1:0] a_rsp_rdata;
    logic          b_req_valid, b_req_wen, b_req_lock;
    logic [AW-1:0] b_req_addr;
    logic [DW-1:0] b_req_wdata;
    logic          b_req_ready, b_rsp_valid;
    logic [DW-1:0] b_rsp_rdata;
    logic [AW-1:0] sram_addr;
    logic          sram_wen, sram_ren;
    logic [DW-1:0] sram_wdata, sram_rdata;

    sram_sp_arbiter #(.DATA_BIT(DW), .DEPTH(DEP), .ADDR_BIT(AW), .RD_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req_valid(a_req_valid), .a_req_wen(a_req_wen), .a_req_lock(a_req_lock),
        .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata), .a_req_ready(a_req_ready),
        .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
        .b_req_valid(b_req_valid), .b_req_wen(b_req_wen), .b_req_lock(b_req_lock),
        .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata), .b_req_ready(b_req_ready),
        .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
        .sram_addr(sram_addr), .sram_wen(sram_wen), .sram_ren(sram_ren),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- SRAM behavioural model ----------------
    logic [DW-1:0] sram_mem [DEP];
    logic [DW-1:0] rd_pipe  [LAT];
    always @(posedge clk) begin
        if (sram_wen) sram_mem[sram_addr] <= sram_wdata;
        rd_pipe[0] <= sram_ren ? sram_mem[sram_addr] : '0;
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign sram_rdata = rd_pipe[LAT-1];

    // ---------------- reference model state ----------------
    logic [DW-1:0] ref_mem [DEP];
    int            prio;      // 0 = A preferred, 1 = B preferred
    int            locked;    // -1 none, else port holding the lock
    int            run_len;   // consecutive grants under the current lock
    logic [EW-1:0] exp_q[$];  // {due cycle, port, data}
    int            dut_log[$];
    int            checks = 0;
    int            failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic model_reset();
        prio    = 0;
        locked  = -1;
        run_len = 0;
    endtask

    // ---------------- driver ----------------
    task automatic set_a(input logic v, input logic w, input logic l,
                         input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        a_req_valid = v; a_req_wen = w; a_req_lock = l; a_req_addr = ad; a_req_wdata = wd;
    endtask

    task automatic set_b(input logic v, input logic w, input logic l,
                         input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        b_req_valid = v; b_req_wen = w; b_req_lock = l; b_req_addr = ad; b_req_wdata = wd;
    endtask

    // One cycle: predict the grant from the driven inputs, compare, then advance the model.
    task automatic step();
        logic          v [2];
        logic          lk[2];
        logic          wn[2];
        logic [AW-1:0] ad[2];
        logic [DW-1:0] wd[2];
        logic [31:0]   due;
        int            g;
        @(negedge clk);
        v[0] = a_req_valid; lk[0] = a_req_lock; wn[0] = a_req_wen; ad[0] = a_req_addr; wd[0] = a_req_wdata;
        v[1] = b_req_valid; lk[1] = b_req_lock; wn[1] = b_req_wen; ad[1] = b_req_addr; wd[1] = b_req_wdata;
        g = -1;
        if (rst_n) begin
            if (locked >= 0) begin
                if (v[locked]) g = locked;
            end else if (v[0] && v[1]) g = prio;
            else if (v[0]) g = 0;
            else if (v[1]) g = 1;
        end
        dut_log.push_back(a_req_ready ? 0 : (b_req_ready ? 1 : 2));
        check("req_ready", {a_req_ready, b_req_ready}, {g == 0, g == 1});
        check("ready_onehot", a_req_ready & b_req_ready, 0);
        check("sram_wen_ren_excl", sram_wen & sram_ren, 0);
        if (g >= 0) begin
            check("sram_en", {sram_wen, sram_ren}, {wn[g], ~wn[g]});
            check("sram_addr", sram_addr, ad[g]);
            check("sram_wdata", sram_wdata, wd[g]);
            if (wn[g]) ref_mem[ad[g]] = wd[g];
            else begin
                due = cyc + LAT;
                exp_q.push_back({due, g[0], ref_mem[ad[g]]});
            end
        end else begin
            check("sram_idle", {sram_wen, sram_ren, sram_addr, sram_wdata}, 0);
        end
        if (rst_n) begin
            if (locked < 0) begin
                if (g >= 0) begin
                    if (lk[g]) begin locked = g; run_len = 1; end
                    else prio = 1 - g;
                end
            end else if (g >= 0 && lk[g] && run_len + 1 < 16) begin
                run_len++;
            end else begin
                prio   = 1 - locked;
                locked = -1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int n);
        rst_n = 1'b0;
        exp_q.delete();
        model_reset();
        repeat (n) step();
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        set_a(0, 0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0);
        repeat (n) step();
    endtask

    // ---------------- response monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        logic [DW-1:0] got;
        check("rsp_both_valid", a_rsp_valid & b_rsp_valid, 0);
        if (!a_rsp_valid) check("a_rdata_idle", a_rsp_rdata, 0);
        if (!b_rsp_valid) check("b_rdata_idle", b_rsp_rdata, 0);
        if (a_rsp_valid || b_rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", {a_rsp_valid, b_rsp_valid}, 0);
            end else begin
                e   = exp_q.pop_front();
                got = b_rsp_valid ? b_rsp_rdata : a_rsp_rdata;
                check("rsp_port", b_rsp_valid, e[DW]);
                check("rsp_cycle", cyc, e[EW-1 -: 32]);
                check("rsp_data", got, e[DW-1:0]);
            end
        end else if (exp_q.size() != 0 && exp_q[0][EW-1 -: 32] <= cyc) begin
            e = exp_q.pop_front();
            check("rsp_missing", {a_rsp_valid, b_rsp_valid}, e[DW] ? 2'b01 : 2'b10);
        end
    end

    // ---------------- stimulus ----------------
    task automatic rand_port(input int lock_pct, output logic v, output logic w, output logic l,
                             output logic [AW-1:0] ad, output logic [DW-1:0] wd);
        v  = $urandom_range(0, 9) < 7;
        w  = $urandom_range(0, 1) == 1;
        l  = $urandom_range(0, 99) < lock_pct;
        ad = AW'($urandom_range(0, DEP - 1));
        wd = $urandom;
    endtask

    initial begin
        logic          rv, rw, rl;
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;
        int            base;
        for (int i = 0; i < DEP; i++) begin
            sram_mem[i] = 32'hC0DE_0000 + i;
            ref_mem[i]  = 32'hC0DE_0000 + i;
        end
        sram_mem[5] = 32'hAA;
        ref_mem[5]  = 32'hAA;
        for (int i = 0; i < LAT; i++) rd_pipe[i] = '0;

        // Reset with both ports requesting: nothing may be granted.
        set_a(1, 0, 0, 1, 0);
        set_b(1, 1, 0, 2, 32'h55);
        apply_reset(3);

        // Scenario 1: single read of addr 5.
        idle(0);
        set_a(1, 0, 0, 5, 0);
        step();
        idle(LAT + 2);

        // Scenario 2: both ports reading every cycle, grants alternate from A.
        apply_reset(1);
        base = dut_log.size();
        for (int i = 0; i < 8; i++) begin
            set_a(1, 0, 0, AW'(i), 0);
            set_b(1, 0, 0, AW'(i + 8), 0);
            step();
        end
        for (int i = 0; i < 8; i++) check("alt_grant", dut_log[base + i], i % 2);
        idle(LAT + 2);

        // Scenario 3: A holds lock for 20 cycles while B waits.
        apply_reset(1);
        base = dut_log.size();
        for (int i = 0; i < 20; i++) begin
            set_a(1, 1, 1, AW'(i % DEP), $urandom);
            set_b(1, 0, 0, 3, 0);
            step();
        end
        for (int i = 0; i < 18; i++) check("lock_grant", dut_log[base + i], (i == 16) ? 1 : 0);
        idle(LAT + 2);

        // Scenario 4: write then read-after-write from the other port.
        set_a(1, 1, 0, 7, 32'h1234);
        step();
        set_a(0, 0, 0, 0, 0);
        set_b(1, 0, 0, 7, 0);
        step();
        idle(LAT + 2);

        // Scenario 5: reset with two reads in flight, then A wins first.
        set_a(1, 0, 0, 1, 0);
        step();
        set_a(0, 0, 0, 0, 0);
        set_b(1, 0, 0, 2, 0);
        step();
        set_a(1, 0, 0, 4, 0);
        set_b(1, 0, 0, 6, 0);
        apply_reset(2);
        base = dut_log.size();
        step();
        check("post_reset_grant", dut_log[base], 0);
        idle(LAT + 3);

        // Scenario 6: random traffic, light then heavy locking.
        for (int i = 0; i < 10000; i++) begin
            rand_port(i < 5000 ? 20 : 90, rv, rw, rl, ra, rd);
            set_a(rv, rw, rl, ra, rd);
            rand_port(i < 5000 ? 20 : 90, rv, rw, rl, ra, rd);
            set_b(rv, rw, rl, ra, rd);
            step();
        end
        idle(LAT + 4);
        check("drain_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_sp_arbiter.md
SRAM_SP_ARBITER -- requirements
Module: sram_sp_arbiter

Interface
REQ-001: Parameter DATA_BIT, default 128, SHALL set the word width of the requester and SRAM data buses.
REQ-002: Parameter DEPTH, default 128, SHALL set the number of SRAM words.
REQ-003: Parameter ADDR_BIT, default $clog2(DEPTH), SHALL set the address width.
REQ-004: Parameter RD_LAT, default 2, range 1..4, SHALL set the cycles from the SRAM read-issue edge to valid sram_rdata.
REQ-005: Ports SHALL be, in order:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a_req_valid  input  1  port A request present.
- a_req_wen  input  1  port A: 1 = write, 0 = read.
- a_req_lock  input  1  port A asks to keep the grant next cycle.
- a_req_addr  input  ADDR_BIT  port A address.
- a_req_wdata  input  DATA_BIT  port A write data.
- a_req_ready  output  1  port A request accepted this cycle.
- a_rsp_valid  output  1  port A read data valid.
- a_rsp_rdata  output  DATA_BIT  port A read data.
- b_* (7 ports)  same as a_*  port B, identical meaning.
- sram_addr  output  ADDR_BIT  SRAM address.
- sram_wen  output  1  SRAM write enable, active high.
- sram_ren  output  1  SRAM read enable, active high.
- sram_wdata  output  DATA_BIT  SRAM write data.
- sram_rdata  input  DATA_BIT  SRAM read data.

Function
REQ-006: A request SHALL transfer on a rising edge where x_req_valid=1 and x_req_ready=1.
REQ-007: At most one of a_req_ready and b_req_ready SHALL be 1 in any cycle.
REQ-008: x_req_ready SHALL be combinational from the valid inputs and arbiter state.
REQ-009: The SRAM outputs SHALL be a combinational mux of the granted port's fields, so one transfer equals one SRAM access in the same cycle.
- sram_wen = granted & wen.
- sram_ren = granted & ~wen.
REQ-010: With no transfer, sram_wen=0, sram_ren=0, and sram_addr/sram_wdata SHALL be 0.
REQ-011: Arbiter FSM states SHALL be RR_A (A has priority), RR_B (B has priority), LOCK_A and LOCK_B.
REQ-012: In RR_x, when only one port is valid, that port SHALL be granted; when both are valid, port x SHALL be granted.
REQ-013: After a grant in RR states, the next state SHALL be LOCK_g if the granted port's lock=1, else RR of the non-granted port.
REQ-014: With no grant in RR_x, the state SHALL stay RR_x.
REQ-015: In LOCK_x, only port x SHALL be granted; the other port's ready is 0 even if x is not valid.
REQ-016: LOCK_x SHALL stay while (x valid & lock) on the transfer cycle.
REQ-017: LOCK_x SHALL go to RR of the other port when x transfers with lock=0, or when x_req_valid=0.
REQ-018: A lock held continuously for 16 consecutive grants SHALL be forcibly released to RR of the other port after the 16th grant; this uses a 4-bit burst counter that is cleared on each entry to LOCK.
REQ-019: Each read issue SHALL push a 2-bit tag {valid, port} into a RD_LAT-deep shift register; writes and idle cycles SHALL push tag 0.
REQ-020: When the tag leaving stage RD_LAT is valid, the matching x_rsp_valid SHALL be 1 for exactly one cycle, with x_rsp_rdata=sram_rdata.
REQ-021: Read response latency SHALL be exactly RD_LAT cycles after the transfer edge, in issue order; responses cannot be back-pressured.
REQ-022: x_rsp_rdata SHALL be 0 when x_rsp_valid=0.
REQ-023: Back-to-back reads, alternating ports, SHALL sustain one access per cycle.
REQ-024: A read to an address written in an earlier cycle SHALL return the new data; there is no reordering, so no hazard logic is needed.

Reset
REQ-025: On rst_n=0, the following SHALL clear asynchronously:
- FSM to RR_A.
- Burst counter to 0.
- Tag pipe to all-invalid.
- a/b_rsp_valid=0.
REQ-026: While rst_n=0, x_req_ready=0, sram_wen=0 and sram_ren=0.
REQ-027: Reads in flight at reset SHALL be dropped, with no rsp_valid after reset release.

Verification
REQ-028: Scenario 1: reset, then A reads addr 5 (mem[5]=0xAA) -> a_req_ready=1 at cycle 0, sram_ren=1 with sram_addr=5, a_rsp_valid=1 with data 0xAA at cycle RD_LAT=2, b_rsp_valid stays 0.
REQ-029: Scenario 2: A and B valid every cycle, lock=0, from reset -> grants A,B,A,B..., 1 access/cycle, responses routed to the correct port in order.
REQ-030: Scenario 3: A valid with lock=1 for 20 cycles, B valid throughout -> A granted 16 consecutive times, then B granted, then A.
REQ-031: Scenario 4: A writes 0x1234 to addr 7 and B reads addr 7 the next cycle -> b_rsp_rdata=0x1234.
REQ-032: Scenario 5: rst_n asserted 1 cycle after two reads issue -> no rsp_valid after release; first post-reset grant goes to A when both ports are valid.
REQ-033: Scenario 6: random traffic for 10k cycles against a reference memory model -> every read matches, ready is one-hot-or-zero, and sram_wen & sram_ren never both 1.
